// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch/decode boundary.
package fetch_pkg;

    // Encoding decode treats as a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0800_0000;

    // Instruction memory base; fetch starts here out of reset.
    localparam logic [31:0] RESET_PC  = 32'h0000_2000;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        WAIT_LOW
    } int_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular storage of {pc, instr} pairs with push/pop/clear and occupancy count.
module fetch_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_pc,
    input  logic [WIDTH-1:0]         wr_instr,
    output logic [WIDTH-1:0]         head_pc,
    output logic [WIDTH-1:0]         head_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Next pointers/count; clear drops everything by snapping rd_ptr onto wr_ptr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable once counted, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem_q[wr_ptr_q]    <= wr_pc;
            instr_mem_q[wr_ptr_q] <= wr_instr;
        end
    end

    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue with flush handling and interrupt instruction injection.
module fetch_queue #(
    parameter int unsigned           DEPTH    = 4,
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = WIDTH'(fetch_pkg::RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic [WIDTH-1:0]         in_pc,
    output logic                     full,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         flush_pc,
    input  logic                     INT,
    input  logic [WIDTH-1:0]         INT_INST,
    output logic                     ACK,
    input  logic                     dec_stall,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_instr,
    output logic [WIDTH-1:0]         out_pc,
    output logic                     out_is_int,
    output logic [$clog2(DEPTH):0]   count
);

    import fetch_pkg::*;

    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR);

    int_state_t       state_q, state_d;
    logic [WIDTH-1:0] resume_pc_q, resume_pc_d;
    logic [WIDTH-1:0] head_pc, head_instr;
    logic             empty;
    logic             push, pop;

    // full reflects occupancy before this cycle's pop: no write pass-through.
    assign push = in_valid & ~full & ~flush;
    assign pop  = ~empty & ~dec_stall & ~flush & (state_q == IDLE);

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .clear      (flush),
        .wr_pc      (in_pc),
        .wr_instr   (in_instr),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Resume PC tracks the next sequential PC after the last instruction decode took.
    always_comb begin
        resume_pc_d = resume_pc_q;
        if (flush) begin
            resume_pc_d = flush_pc;
        end else if (pop) begin
            resume_pc_d = head_pc + WIDTH'(4);
        end
    end

    // Interrupt FSM state and resume PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            resume_pc_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            resume_pc_q <= resume_pc_d;
        end
    end

    // Next-state and output mux; WAIT_LOW holds the queue until INT drops.
    always_comb begin
        state_d    = state_q;
        ACK        = 1'b0;
        out_valid  = 1'b0;
        out_instr  = NOP;
        out_pc     = '0;
        out_is_int = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    out_valid = 1'b1;
                    out_instr = head_instr;
                    out_pc    = head_pc;
                end
                if (INT) state_d = INJECT;
            end
            INJECT: begin
                out_valid  = 1'b1;
                out_instr  = INT_INST;
                out_is_int = 1'b1;
                out_pc     = empty ? resume_pc_q : head_pc;
                if (!dec_stall) begin
                    ACK     = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!INT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expectations, monitor checks accepts.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0800_0000;
    localparam logic [31:0] IRQ = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        full;
    logic        flush;
    logic [31:0] flush_pc;
    logic        INT;
    logic [31:0] INT_INST;
    logic        ACK;
    logic        dec_stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_int;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_int;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fetch_queue #(
        .DEPTH    (4),
        .WIDTH    (32),
        .RESET_PC (32'h0000_2000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .full       (full),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .INT        (INT),
        .INT_INST   (INT_INST),
        .ACK        (ACK),
        .dec_stall  (dec_stall),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_is_int (out_is_int),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr, input logic is_int);
        exp_t e;
        e.pc     = pc;
        e.instr  = instr;
        e.is_int = is_int;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (count != 3'd0 && n < 50) begin
            step();
            n++;
        end
        check(name, 32'(count), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},   32'(count),      32'd0);
        check({tag, "_full"},    32'(full),       32'd0);
        check({tag, "_valid"},   32'(out_valid),  32'd0);
        check({tag, "_instr"},   out_instr,       NOP);
        check({tag, "_pc"},      out_pc,          32'd0);
        check({tag, "_is_int"},  32'(out_is_int), 32'd0);
        check({tag, "_ack"},     32'(ACK),        32'd0);
    endtask

    // Monitor: every decode accept must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && !dec_stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h instr %h required no output",
                         out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                check("mon_pc",     out_pc,            e.pc);
                check("mon_instr",  out_instr,         e.instr);
                check("mon_is_int", 32'(out_is_int),   32'(e.is_int));
                check("mon_ack",    32'(ACK),          32'(e.is_int));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; flush_pc = '0;
        INT = 1'b0; INT_INST = IRQ;
        dec_stall = 1'b1;
        #1;
        check_reset_outputs("reset");
        #1;
        rst = 1'b0;

        // 1: fill past full with decode stalled; fifth push must be dropped.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h2000 + 32'(4 * i);
            in_instr = 32'hA000_0000 + 32'(i);
            if (i < 4) expect_out(in_pc, in_instr, 1'b0);
            step();
            if (i == 3) begin
                check("t1_full",  32'(full),  32'd1);
                check("t1_count", 32'(count), 32'd4);
            end
            if (i == 4) check("t1_drop_count", 32'(count), 32'd4);
        end
        in_valid  = 1'b0;
        dec_stall = 1'b0;
        wait_empty("t1_drain");

        // 2: steady push+pop at count=2 across several pointer wraps.
        dec_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h4000 + 32'(4 * i);
            in_instr = 32'hC000_0000 + 32'(i);
            expect_out(in_pc, in_instr, 1'b0);
            step();
        end
        dec_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h4008 + 32'(4 * k);
            in_instr = 32'hC000_0002 + 32'(k);
            expect_out(in_pc, in_instr, 1'b0);
            step();
            check("t2_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        wait_empty("t2_drain");

        // 3: flush at count=3 with a concurrent fetch; then inject on an empty queue.
        dec_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h5000 + 32'(4 * i);
            in_instr = 32'hE000_0000 + 32'(i);
            step();
        end
        check("t3_pre_count", 32'(count), 32'd3);
        flush    = 1'b1;
        flush_pc = 32'h3000;
        in_valid = 1'b1;
        in_pc    = 32'h500C;
        in_instr = 32'hE000_0003;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t3_count", 32'(count),     32'd0);
        check("t3_valid", 32'(out_valid), 32'd0);
        check("t3_instr", out_instr,      NOP);
        INT = 1'b1;
        expect_out(32'h3000, IRQ, 1'b1);
        step();
        check("t3_int_pc", out_pc, 32'h3000);
        dec_stall = 1'b0;
        step();
        INT = 1'b0;
        step();

        // 4: inject ahead of head 0x2008 with a two-cycle stall; INT held afterwards.
        dec_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h2008 + 32'(4 * i);
            in_instr = 32'hB000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        expect_out(32'h2008, IRQ, 1'b1);
        expect_out(32'h2008, 32'hB000_0000, 1'b0);
        expect_out(32'h200C, 32'hB000_0001, 1'b0);
        INT = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("t4_is_int", 32'(out_is_int), 32'd1);
            check("t4_pc",     out_pc,          32'h2008);
            check("t4_ack_stalled", 32'(ACK),   32'd0);
        end
        dec_stall = 1'b0;
        #1;
        check("t4_ack_pulse", 32'(ACK), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("t4_hold_ack",    32'(ACK),        32'd0);
            check("t4_hold_is_int", 32'(out_is_int), 32'd0);
            check("t4_hold_count",  32'(count),      32'd2);
        end
        INT = 1'b0;
        wait_empty("t4_drain");

        // 5: pop 0x2010, then inject into the empty queue at its successor PC.
        in_valid = 1'b1;
        in_pc    = 32'h2010;
        in_instr = 32'hB000_0002;
        expect_out(in_pc, in_instr, 1'b0);
        step();
        in_valid = 1'b0;
        wait_empty("t5_drain");
        dec_stall = 1'b1;
        INT = 1'b1;
        expect_out(32'h2014, IRQ, 1'b1);
        step();
        check("t5_int_pc",  out_pc,          32'h2014);
        check("t5_is_int",  32'(out_is_int), 32'd1);
        dec_stall = 1'b0;
        step();
        INT = 1'b0;
        step();

        // 6: asynchronous reset while injecting with two entries queued.
        dec_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h6000 + 32'(4 * i);
            in_instr = 32'hF000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        INT = 1'b1;
        step();
        check("t6_is_int", 32'(out_is_int), 32'd1);
        #2;
        rst       = 1'b1;
        dec_stall = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        INT = 1'b0;
        step();
        rst = 1'b0;

        // Resume PC must be back at the reset base.
        dec_stall = 1'b1;
        INT = 1'b1;
        expect_out(32'h2000, IRQ, 1'b1);
        step();
        check("t6_resume_pc", out_pc, 32'h2000);
        dec_stall = 1'b0;
        step();
        INT = 1'b0;
        step();
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between fetch and decode: a small FIFO of {pc, instr} pairs.
- Absorbs fetch latency and decode stalls, and drives fetch's `stall` input via `full`.
- Owns the flush of in-flight instructions.
- Owns interrupt injection: places INT_INST in front of the queue head and returns an ACK to the interrupt source.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, ≥2).
- WIDTH, 32, instruction and PC width.
- RESET_PC, 32'h0000_2000, initial resume PC (instruction memory base).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch Done; in_instr/in_pc valid this cycle.
- in_instr  in  WIDTH  fetched instruction.
- in_pc  in  WIDTH  PC of fetched instruction.
- full  out  1  queue full; tied to fetch stall.
- flush  in  1  branch/jump taken; discard all queued entries.
- flush_pc  in  WIDTH  redirect target accompanying flush.
- INT  in  1  interrupt request, level, held until ACK.
- INT_INST  in  WIDTH  instruction to inject for the interrupt.
- ACK  out  1  one-cycle pulse when the injected instruction is accepted by decode.
- dec_stall  in  1  decode cannot accept this cycle.
- out_valid  out  1  out_instr/out_pc valid to decode.
- out_instr  out  WIDTH  instruction to decode; NOP when out_valid=0.
- out_pc  out  WIDTH  PC of out_instr (return PC for injected instruction).
- out_is_int  out  1  out_instr is the injected interrupt instruction.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset (async, rst=1):
- count=0, full=0, out_valid=0, out_instr=NOP (32'h0800_0000), out_pc=0, out_is_int=0, ACK=0.
- FSM=IDLE; resume_pc=RESET_PC.

Queue:
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
- full is true when count==DEPTH.
- push = in_valid & ~full & ~flush.
- full is evaluated before the same-cycle pop. There is no pass-through: a write when full is dropped, and fetch must hold.
- pop = (count>0) & ~dec_stall & ~flush & (FSM==IDLE).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Output is head-of-queue combinational read: out_valid=(count>0) in IDLE; out_instr/out_pc are the head entry.
- Empty queue: out_instr=NOP and out_valid=0.
- On each pop: resume_pc <= popped pc + 4 (WIDTH-bit wrap).

Flush:
- Next edge: count=0, rd_ptr=wr_ptr, resume_pc <= flush_pc.
- A same-cycle in_valid is discarded.
- flush does not cancel a pending or in-progress interrupt.

Interrupt FSM (states IDLE, INJECT, WAIT_LOW):
- IDLE -> INJECT when INT=1.
- In INJECT:
  - out_valid=1, out_instr=INT_INST, out_is_int=1.
  - out_pc = head pc if count>0, else resume_pc.
  - Queue pops are suppressed; pushes continue normally.
- INJECT -> WAIT_LOW when dec_stall=0. ACK=1 for exactly that cycle (combinational from state & ~dec_stall) and is registered as the handshake.
- WAIT_LOW -> IDLE when INT=0. Normal pops resume in WAIT_LOW only after INT drops, which prevents double injection.
- Flush during INJECT: the queue clears and out_pc switches to resume_pc (=flush_pc) from the next cycle.
- Reset mid-operation returns to reset values immediately; no ACK is issued.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant.
  - int_state_t enum {IDLE, INJECT, WAIT_LOW}.
  - RESET_PC constant, shared with fetch.
- One natural sub-module: fetch_queue_fifo, the storage, pointers and count, with push/pop/clear inputs. The top level holds the interrupt FSM, resume_pc and output muxing.

Test Plan:
1. Reset then 5 back-to-back pushes (pc 0x2000..0x2010) with dec_stall=1:
   - full after the 4th push; count=4; the 5th push is dropped.
   - After dec_stall drops, pcs come out 0x2000..0x200C in order.
2. Simultaneous push/pop with count=2 for 10 cycles:
   - count stays 2; pointers wrap past DEPTH; order is preserved.
3. flush with flush_pc=0x3000 while count=3 and in_valid=1:
   - Next cycle count=0, out_valid=0, out_instr=NOP.
   - Later injection with an empty queue gives out_pc=0x3000.
4. INT=1, INT_INST=0xDEAD_BEEF, head pc=0x2008, dec_stall=1 for 2 cycles:
   - out_is_int=1 and out_pc=0x2008 throughout.
   - ACK is a single pulse on the first cycle dec_stall=0.
   - With INT held high, no second injection occurs; the queue resumes after INT=0.
5. INT with an empty queue after popping pc 0x2010:
   - Injected out_pc=0x2014.
6. rst asserted while in INJECT with count=2:
   - All outputs return to reset values asynchronously; no ACK.
